// File: rtl/ring_counter_ext.sv
// Configurable ring counter: one-hot ring (MODE 0) or Johnson (MODE 1) with
// load/clear, direction control, phase decode, wrap and fault events.
module ring_counter_ext #(
   parameter int unsigned CYCLE = 8,
   parameter int unsigned MODE  = 0,
   localparam int unsigned QW   = (MODE == 1) ? CYCLE / 2 : CYCLE,
   localparam int unsigned IDXW = ($clog2(CYCLE) > 1) ? $clog2(CYCLE) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clk_en,
   input  logic            dir,
   input  logic            clr,
   input  logic            load,
   input  logic [IDXW-1:0] load_idx,
   output logic [QW-1:0]   q,
   output logic [IDXW-1:0] idx,
   output logic            pulse,
   output logic            wrap,
   output logic            err
);

   if (CYCLE < 2 || MODE > 1 || (MODE == 1 && ((CYCLE % 2) != 0 || CYCLE < 4))) begin : g_param_check
      $error("ring_counter_ext: unsupported CYCLE/MODE combination");
   end

   // Encoding of phase s, built bit by bit so that no adder is needed.
   function automatic logic [QW-1:0] enc(input int unsigned s);
      logic [QW-1:0] r;
      r = '0;
      for (int unsigned b = 0; b < QW; b++) begin
         if (MODE == 0) r[b] = (b == s);
         else if (s <= QW) r[b] = (b < s);
         else r[b] = (b >= s - QW);
      end
      return r;
   endfunction

   localparam logic [QW-1:0] PHASE0 = enc(0);

   logic [QW-1:0]   q_reg;
   logic [QW-1:0]   q_fwd;
   logic [QW-1:0]   q_rev;
   logic [QW-1:0]   q_next;
   logic [IDXW-1:0] cur_idx;
   logic            legal;
   logic            term;
   logic            load_ok;
   logic [QW-1:0]   load_q;
   logic            wrap_next;
   logic            err_next;

   if (MODE == 0) begin : g_ring
      assign q_fwd = {q_reg[QW-2:0], q_reg[QW-1]};
      assign q_rev = {q_reg[0], q_reg[QW-1:1]};
   end else begin : g_johnson
      assign q_fwd = {q_reg[QW-2:0], ~q_reg[QW-1]};
      assign q_rev = {~q_reg[0], q_reg[QW-1:1]};
   end

   // Decode by matching against every legal pattern; no match means illegal.
   always_comb begin
      legal   = 1'b0;
      cur_idx = '0;
      load_ok = 1'b0;
      load_q  = PHASE0;
      for (int unsigned s = 0; s < CYCLE; s++) begin
         if (q_reg == enc(s)) begin
            legal   = 1'b1;
            cur_idx = IDXW'(s);
         end
         if (load_idx == IDXW'(s)) begin
            load_ok = 1'b1;
            load_q  = enc(s);
         end
      end
   end

   assign term  = dir ? (cur_idx == '0) : (cur_idx == IDXW'(CYCLE - 1));
   assign pulse = legal & term;
   assign idx   = cur_idx;
   assign q     = q_reg;

   always_comb begin
      q_next    = q_reg;
      wrap_next = 1'b0;
      err_next  = 1'b0;
      if (!legal) begin
         q_next   = PHASE0;
         err_next = 1'b1;
      end else if (clr) begin
         q_next = PHASE0;
      end else if (load) begin
         if (load_ok) q_next = load_q;
         else err_next = 1'b1;
      end else if (clk_en) begin
         q_next    = dir ? q_rev : q_fwd;
         wrap_next = term;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg <= PHASE0;
         wrap  <= 1'b0;
         err   <= 1'b0;
      end else begin
         q_reg <= q_next;
         wrap  <= wrap_next;
         err   <= err_next;
      end
   end

endmodule
